// File: rtl/mips_top_cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core: opcode/funct codes,
// ALU operation set, data-bus register addresses and the seven-segment hex font.
// No logic of its own; imported by mips_top_cpu and mips_top_cpu_seg_scan.
package mips_top_cpu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_e;

  // Memory-mapped peripheral registers (word addresses, bits [1:0] ignored)
  localparam logic [31:0] LED_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] SEG_ADDR = 32'hFFFF_0004;

  // Active-low {dp,g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
  localparam logic [15:0][7:0] HEX_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // b is the second operand; shifts act on b by sh, LUI places b[15:0] high.
  function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] y;
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_SLL:  y = b << sh;
      ALU_SRL:  y = b >> sh;
      ALU_SRA:  y = $unsigned($signed(b) >>> sh);
      ALU_LUI:  y = {b[15:0], 16'h0000};
      default:  y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_top_cpu_seg_scan.sv
// Seven-segment scanner: rotates one active-low anode per counter wrap and
// drives the hex glyph of the matching nibble of seg_val.
// Ports: clk, rst (async active-low), seg_val[15:0] in; seg_an[3:0], seg_cat[7:0] out.
module mips_top_cpu_seg_scan
  import mips_top_cpu_pkg::*;
#(
  parameter int SCAN_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seg_val,
  output logic [3:0]  seg_an,
  output logic [7:0]  seg_cat
);

  logic [SCAN_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]           digit_q, digit_d;
  logic [3:0]           nibble;

  always_comb begin
    cnt_d   = cnt_q + SCAN_BITS'(1);
    digit_d = digit_q;
    // Advance the digit on the edge where the counter rolls over.
    if (&cnt_q) digit_d = digit_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      digit_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  assign nibble  = seg_val[{digit_q, 2'b00} +: 4];
  assign seg_an  = ~(4'b0001 << digit_q);
  assign seg_cat = HEX_FONT[nibble];

endmodule

// File: rtl/mips_top_cpu.sv
// Single-cycle MIPS-subset CPU: one instruction retired per clk from a combinational
// IRAM; data bus serves a data RAM, an LED register and a seven-segment register.
// Ports: clk, rst (async active-low), iram_indata in; iram_addr (PC), led, seg_an, seg_cat out.
// Build option: define SEG_DISPLAY_EN to compile in the display scanner; otherwise
// seg_an/seg_cat are held dark while the seg register stays on the bus.
module mips_top_cpu
  import mips_top_cpu_pkg::*;
#(
  parameter int DMEM_WORDS = 64,
  parameter int SCAN_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iram_indata,
  output logic [31:0] iram_addr,
  output logic [15:0] led,
  output logic [3:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int DA_W = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [15:0] led_q, led_d;
  logic [15:0] seg_q, seg_d;
  logic [31:0] dmem [DMEM_WORDS];

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext_imm, zext_imm, pc_plus4, branch_tgt, jump_tgt;
  logic [31:0] rs_val, rt_val;

  assign op       = iram_indata[31:26];
  assign rs       = iram_indata[25:21];
  assign rt       = iram_indata[20:16];
  assign rd       = iram_indata[15:11];
  assign shamt    = iram_indata[10:6];
  assign funct    = iram_indata[5:0];
  assign sext_imm = {{16{iram_indata[15]}}, iram_indata[15:0]};
  assign zext_imm = {16'h0000, iram_indata[15:0]};

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign jump_tgt   = {pc_plus4[31:28], iram_indata[25:0], 2'b00};

  // r0 is never written, so it stays at its reset value of zero.
  assign rs_val = regs_q[rs];
  assign rt_val = regs_q[rt];

  // Decode
  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y, pc_next;
  logic        rf_we, bus_we;
  logic [4:0]  rf_waddr;
  wb_sel_e     wb_sel;

  always_comb begin
    alu_op   = ALU_ADD;
    alu_b    = rt_val;
    rf_we    = 1'b0;
    rf_waddr = rd;
    wb_sel   = WB_ALU;
    bus_we   = 1'b0;
    pc_next  = pc_plus4;
    case (op)
      OP_RTYPE: begin
        rf_we = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:         alu_op = ALU_AND;
          F_OR:          alu_op = ALU_OR;
          F_XOR:         alu_op = ALU_XOR;
          F_NOR:         alu_op = ALU_NOR;
          F_SLT:         alu_op = ALU_SLT;
          F_SLTU:        alu_op = ALU_SLTU;
          F_SLL:         alu_op = ALU_SLL;
          F_SRL:         alu_op = ALU_SRL;
          F_SRA:         alu_op = ALU_SRA;
          F_JR: begin
            rf_we   = 1'b0;
            pc_next = rs_val;
          end
          default:       rf_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu_b = sext_imm; rf_we = 1'b1; rf_waddr = rt; end
      OP_SLTI:  begin alu_op = ALU_SLT;  alu_b = sext_imm; rf_we = 1'b1; rf_waddr = rt; end
      OP_SLTIU: begin alu_op = ALU_SLTU; alu_b = sext_imm; rf_we = 1'b1; rf_waddr = rt; end
      OP_ANDI:  begin alu_op = ALU_AND;  alu_b = zext_imm; rf_we = 1'b1; rf_waddr = rt; end
      OP_ORI:   begin alu_op = ALU_OR;   alu_b = zext_imm; rf_we = 1'b1; rf_waddr = rt; end
      OP_XORI:  begin alu_op = ALU_XOR;  alu_b = zext_imm; rf_we = 1'b1; rf_waddr = rt; end
      OP_LUI:   begin alu_op = ALU_LUI;  alu_b = zext_imm; rf_we = 1'b1; rf_waddr = rt; end
      OP_LW: begin
        alu_b    = sext_imm;
        rf_we    = 1'b1;
        rf_waddr = rt;
        wb_sel   = WB_MEM;
      end
      OP_SW: begin
        alu_b  = sext_imm;
        bus_we = 1'b1;
      end
      OP_BEQ: if (rs_val == rt_val) pc_next = branch_tgt;
      OP_BNE: if (rs_val != rt_val) pc_next = branch_tgt;
      OP_J:   pc_next = jump_tgt;
      OP_JAL: begin
        pc_next  = jump_tgt;
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        wb_sel   = WB_LINK;
      end
      default: ;
    endcase
  end

  assign alu_y = alu_calc(alu_op, rs_val, alu_b, shamt);

  // Data bus: the ALU result is the effective address for lw/sw.
  logic            sel_dmem, sel_led, sel_seg;
  logic [DA_W-1:0] dmem_idx;
  logic [31:0]     bus_rdata, rf_wdata;

  assign sel_dmem = (alu_y[31:DA_W+2] == '0);
  assign sel_led  = (alu_y[31:2] == LED_ADDR[31:2]);
  assign sel_seg  = (alu_y[31:2] == SEG_ADDR[31:2]);
  assign dmem_idx = alu_y[DA_W+1:2];

  always_comb begin
    bus_rdata = '0;
    if (sel_dmem)     bus_rdata = dmem[dmem_idx];
    else if (sel_led) bus_rdata = {16'h0000, led_q};
    else if (sel_seg) bus_rdata = {16'h0000, seg_q};
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  rf_wdata = bus_rdata;
      WB_LINK: rf_wdata = pc_plus4;
      default: rf_wdata = alu_y;
    endcase
  end

  // Next architectural state
  always_comb begin
    pc_d = pc_next;
    for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
    if (rf_we && (rf_waddr != 5'd0)) regs_d[rf_waddr] = rf_wdata;
    led_d = led_q;
    seg_d = seg_q;
    if (bus_we && sel_led) led_d = rt_val[15:0];
    if (bus_we && sel_seg) seg_d = rt_val[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      led_q <= '0;
      seg_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      led_q <= led_d;
      seg_q <= seg_d;
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  // RAM contents are never cleared; rst only blocks a store on an edge that
  // arrives while reset is held, so an aborted sw leaves memory untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && bus_we && sel_dmem) dmem[dmem_idx] <= rt_val;
  end

  assign iram_addr = pc_q;
  assign led       = led_q;

  // A scan counter needs at least one bit to wrap.
  if (SCAN_BITS < 1) begin : g_bad_scan_bits
    $error("SCAN_BITS must be at least 1");
  end

`ifdef SEG_DISPLAY_EN
  mips_top_cpu_seg_scan #(
    .SCAN_BITS(SCAN_BITS)
  ) u_seg_scan (
    .clk     (clk),
    .rst     (rst),
    .seg_val (seg_q),
    .seg_an  (seg_an),
    .seg_cat (seg_cat)
  );
`else
  assign seg_an  = 4'b1111;
  assign seg_cat = 8'hFF;
`endif

endmodule

// File: tb/tb_mips_top_cpu.sv
// Directed programs plus randomized ALU/memory programs, checked every cycle
// against an instruction-level reference interpreter kept in this bench.
module tb_mips_top_cpu;

  localparam int SCAN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] iram_indata, iram_addr;
  logic [15:0] led;
  logic [3:0]  seg_an;
  logic [7:0]  seg_cat;

  logic [31:0] imem [1024];
  assign iram_indata = imem[iram_addr[11:2]];

  mips_top_cpu #(.DMEM_WORDS(64), .SCAN_BITS(SCAN)) dut (
    .clk         (clk),
    .rst         (rst),
    .iram_indata (iram_indata),
    .iram_addr   (iram_addr),
    .led         (led),
    .seg_an      (seg_an),
    .seg_cat     (seg_cat)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Standard active-low hex font {dp,g,f,e,d,c,b,a}
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [5:0] rfun [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                            6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
  logic [5:0] iops [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

  // Reference machine state
  logic [31:0] m_pc;
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [64];
  logic [15:0] m_led, m_seg;
  int          m_edges;
  int          wp;

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic put(input logic [31:0] w);
    imem[wp] = w;
    wp++;
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_led   = 16'h0;
    m_seg   = 16'h0;
    m_edges = 0;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] ea);
    if (ea < 32'd256)                       return m_dm[ea[7:2]];
    if ({ea[31:2], 2'b00} == 32'hFFFF_0000) return {16'h0, m_led};
    if ({ea[31:2], 2'b00} == 32'hFFFF_0004) return {16'h0, m_seg};
    return 32'h0;
  endfunction

  task automatic model_store(input logic [31:0] ea, input logic [31:0] v);
    if (ea < 32'd256)                            m_dm[ea[7:2]] = v;
    else if ({ea[31:2], 2'b00} == 32'hFFFF_0000) m_led = v[15:0];
    else if ({ea[31:2], 2'b00} == 32'hFFFF_0004) m_seg = v[15:0];
  endtask

  // Executes one instruction at the ISA level.
  task automatic model_step(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, wa;
    logic [31:0] a, b, sx, zx, npc, res;
    logic        wr;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a = m_rf[rs]; b = m_rf[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    npc = m_pc + 32'd4;
    wr = 1'b0; wa = rt; res = 32'h0;
    case (op)
      6'h00: begin
        wa = rd; wr = 1'b1;
        case (fn)
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: res = (a < b) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = $unsigned($signed(b) >>> sh);
          6'h08: begin wr = 1'b0; npc = a; end
          default: wr = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin wr = 1'b1; res = a + sx; end
      6'h0A: begin wr = 1'b1; res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
      6'h0B: begin wr = 1'b1; res = (a < sx) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = 1'b1; res = a & zx; end
      6'h0D: begin wr = 1'b1; res = a | zx; end
      6'h0E: begin wr = 1'b1; res = a ^ zx; end
      6'h0F: begin wr = 1'b1; res = zx * 32'd65536; end
      6'h23: begin wr = 1'b1; res = model_load(a + sx); end
      6'h2B: model_store(a + sx, b);
      6'h04: if (a == b) npc = npc + sx * 32'd4;
      6'h05: if (a != b) npc = npc + sx * 32'd4;
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin
        wr = 1'b1; wa = 5'd31; res = npc;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    if (wr && wa != 5'd0) m_rf[wa] = res;
    m_pc = npc;
    m_edges++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int         d;
    logic [3:0] an_exp, nib;
    chk({tag, "_pc"},  iram_addr, m_pc);
    chk({tag, "_led"}, {16'h0, led}, {16'h0, m_led});
    d = (m_edges >> SCAN) % 4;
`ifdef SEG_DISPLAY_EN
    an_exp = ~(4'b0001 << d);
    nib    = 4'(m_seg >> (4 * d));
    chk({tag, "_an"},  {28'h0, seg_an},  {28'h0, an_exp});
    chk({tag, "_cat"}, {24'h0, seg_cat}, {24'h0, font[nib]});
`else
    an_exp = 4'hF;
    nib    = 4'(d);
    chk({tag, "_an"},  {28'h0, seg_an},  {28'h0, an_exp});
    chk({tag, "_cat"}, {24'h0, seg_cat}, 32'h0000_00FF);
`endif
  endtask

  task automatic step(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      model_step(imem[m_pc[11:2]]);
      @(negedge clk);
      check_state(tag);
    end
  endtask

  task automatic begin_prog();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    wp = 0;
  endtask

  task automatic end_prog(input string tag);
    @(negedge clk);
    check_state({tag, "_rst"});
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_dm[i] = 32'h0;
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    model_reset();

    // Reset state, then an all-zero (nop) program stepping the PC.
    #100;
    @(negedge clk);
    check_state("reset");
    chk("reset_pc_lit", iram_addr, 32'h0);
`ifdef SEG_DISPLAY_EN
    chk("reset_cat_lit", {24'h0, seg_cat}, 32'h0000_00C0);
`endif
    rst = 1'b1;
    step(5, "nops");
    chk("nops_pc_lit", iram_addr, 32'h14);

    // LED store, then asynchronous reset with no clock edge.
    begin_prog();
    put(i_ins(6'h0D, 5'd0, 5'd1, 16'h00A5));
    put(i_ins(6'h0F, 5'd0, 5'd2, 16'hFFFF));
    put(i_ins(6'h2B, 5'd2, 5'd1, 16'h0000));
    end_prog("ledp");
    step(3, "ledp");
    chk("ledp_lit", {16'h0, led}, 32'h0000_00A5);
    step(2, "ledp");
    #3 rst = 1'b0;
    #1;
    chk("midrst_pc", iram_addr, 32'h0);
    chk("midrst_led", {16'h0, led}, 32'h0);
    model_reset();

    // sltu / beq taken; the fall-through stores would put FFFF on led.
    begin_prog();
    put(i_ins(6'h0F, 5'd0, 5'd2, 16'hFFFF));
    put(32'h0); put(32'h0);
    put(i_ins(6'h08, 5'd0, 5'd3, 16'hFFFF));
    put(r_ins(6'h2B, 5'd0, 5'd3, 5'd4, 5'd0));
    put(i_ins(6'h04, 5'd4, 5'd4, 16'h0002));
    put(i_ins(6'h2B, 5'd2, 5'd3, 16'h0000));
    put(i_ins(6'h2B, 5'd2, 5'd3, 16'h0000));
    put(i_ins(6'h2B, 5'd2, 5'd4, 16'h0000));
    end_prog("br");
    step(6, "br");
    chk("br_pc_lit", iram_addr, 32'h20);
    step(1, "br");
    chk("br_r4_lit", {16'h0, led}, 32'h1);

    // jal / jr round trip, r31 observed via led.
    begin_prog();
    put(i_ins(6'h0F, 5'd0, 5'd2, 16'hFFFF));
    imem[16'h40 >> 2]  = j_ins(6'h03, 26'h100);
    imem[16'h44 >> 2]  = i_ins(6'h2B, 5'd2, 5'd31, 16'h0000);
    imem[16'h400 >> 2] = r_ins(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
    end_prog("jal");
    step(16, "jal");
    step(1, "jal");
    chk("jal_pc_lit", iram_addr, 32'h400);
    step(1, "jal");
    chk("jr_pc_lit", iram_addr, 32'h44);
    step(1, "jal");
    chk("jal_r31_lit", {16'h0, led}, 32'h44);

    // seg register write/read-back and display scan.
    begin_prog();
    put(i_ins(6'h0F, 5'd0, 5'd2, 16'hFFFF));
    put(i_ins(6'h0D, 5'd0, 5'd1, 16'h1234));
    put(i_ins(6'h2B, 5'd2, 5'd1, 16'h0004));
    put(i_ins(6'h23, 5'd2, 5'd5, 16'h0004));
    put(i_ins(6'h2B, 5'd2, 5'd5, 16'h0000));
    end_prog("seg");
    step(5, "seg");
    chk("seg_rd_lit", {16'h0, led}, 32'h1234);
    step(20, "seg");

    // Randomized programs; every register is dumped through led at the end.
    for (int p = 0; p < 4; p++) begin
      begin_prog();
      put(i_ins(6'h0F, 5'd0, 5'd28, 16'hFFFF));
      if (p == 0)
        for (int i = 0; i < 64; i++) put(i_ins(6'h2B, 5'd0, 5'd0, 16'(4 * i)));
      for (int i = 0; i < 40; i++) begin
        int         k;
        logic [4:0] ra, rb, rc;
        k  = int'($urandom_range(0, 10));
        ra = 5'($urandom_range(0, 9));
        rb = 5'($urandom_range(0, 9));
        rc = 5'($urandom_range(0, 9));
        if (k < 4)
          put(r_ins(rfun[$urandom_range(0, 12)], ra, rb, rc, 5'($urandom_range(0, 31))));
        else if (k < 7)
          put(i_ins(iops[$urandom_range(0, 7)], ra, rc, 16'($urandom)));
        else if (k == 7)
          put(i_ins(6'h2B, 5'd0, rb, 16'(4 * $urandom_range(0, 63))));
        else if (k == 8)
          put(i_ins(6'h23, 5'd0, rc, 16'(4 * $urandom_range(0, 63))));
        else if (k == 9)
          put(($urandom_range(0, 1) == 0) ? i_ins(6'h3F, ra, rc, 16'($urandom))
                                          : r_ins(6'h3F, ra, rb, rc, 5'd0));
        else
          put(i_ins(6'h2B, 5'd28, rb, 16'h0004));
      end
      for (int r = 1; r < 10; r++) begin
        put(i_ins(6'h2B, 5'd28, 5'(r), 16'h0000));
        put(r_ins(6'h02, 5'd0, 5'(r), 5'(r), 5'd16));
        put(i_ins(6'h2B, 5'd28, 5'(r), 16'h0000));
      end
      end_prog("rnd");
      step(wp, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_top_cpu.md
# mips_top_cpu

Single-cycle MIPS-subset processor top (module name `top_cpu`) for the FPGA board build. It fetches one 32-bit instruction per clock from an external instruction RAM and executes R-, I- and J-type instructions. A small internal data bus serves a data RAM, a memory-mapped LED register and a memory-mapped seven-segment display register.

## Interface
- DMEM_WORDS, 64: data RAM depth in 32-bit words (power of two).
- SCAN_BITS, 16: seven-segment refresh counter width; the digit advances when the counter wraps.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- iram_indata  in  32  instruction word at `iram_addr`, valid in the same cycle (combinational IRAM read).
- iram_addr  out  32  current PC (byte address), driven directly from the PC register.
- led  out  16  LED register contents.
- seg_an  out  4  digit enables, active-low.
- seg_cat  out  8  segment cathodes {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Every non-reset clock retires exactly one instruction. Register file is 32x32; r0 reads 0 and ignores writes.
- **R-type** (op 0): add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra (shamt), jr. add and sub wrap, with no overflow trap.
- **I-type**:
  - addi/addiu/slti/sltiu use a sign-extended immediate.
  - andi/ori/xori use a zero-extended immediate.
  - lui writes imm<<16.
  - lw and sw use base+sext(imm).
  - beq and bne branch to PC+4+(sext(imm)<<2). There are no delay slots.
- **J-type**: j and jal target {PC+4[31:28], target, 2'b00}. jal writes PC+4 to r31.
- Any undefined opcode or funct executes as a nop (PC+4, no writes). The all-zero word is sll r0 and is a nop.
- **Data bus map** (word aligned; address bits [1:0] ignored):
  - 0x0000_0000 .. 4*DMEM_WORDS-1: data RAM.
  - 0xFFFF_0000: LED register. Writes take bits [15:0]; reads return it zero-extended.
  - 0xFFFF_0004: seg register, four hex digits in bits [15:0]. Reads return it zero-extended.
  - Other addresses: writes are ignored, reads return 0.
- Seven-segment digit i shows hex nibble seg[4i+3:4i] using the standard hex font, with dp always off.

## Timing
- Next PC, register write and bus write all commit on the rising clk edge. lw read data is combinational in the same cycle.
- rst low (asynchronous) forces:
  - PC = 0, all registers = 0, led = 0, seg register = 0, scan counter = 0.
  - Outputs: iram_addr = 0, led = 0, seg_an = 4'b1110, seg_cat = 8'hC0 (digit "0").
- Data RAM contents are not reset.
- When reset is released, the first edge executes the instruction at address 0. Reset asserted mid-instruction aborts it, with no partial writes.
- The PC wraps modulo 2^32.
- Write to r0 from jal is not possible. A jr to a misaligned address is taken as-is, with the low bits passed to `iram_addr`.
- sw to the LED address is visible on `led` from the cycle after the edge.

## Configuration
- SEG_DISPLAY_EN defined: the scan counter, digit multiplexer and hex decoder are compiled in. `seg_an` rotates 1110→1101→1011→0111 each time the SCAN_BITS counter wraps.
- SEG_DISPLAY_EN undefined:
  - The seg register stays bus-readable and writable.
  - seg_an = 4'b1111 and seg_cat = 8'hFF constantly.
  - No scan logic is generated.

## Structure
- Shared package `top_cpu_pkg` holds:
  - opcode and funct constants;
  - the ALU operation enum;
  - bus address constants (LED_ADDR, SEG_ADDR);
  - the hex-to-segment constant table.
- One natural sub-module is `seg_scan` (counter, anode rotation, hex decode). The datapath, decoder, register file and bus stay in `top_cpu`.

## Test plan
- rst low for 100 ns, iram_indata = 0, 20 ns clock, then release → iram_addr steps 0, 4, 8, … one step per clock; led = 0; seg_cat = 8'hC0.
- Program: ori r1,r0,0x00A5; lui r2,0xFFFF; sw r1,0(r2) → led = 16'h00A5 after the third edge.
- addi r3,r0,-1; sltu r4,r0,r3; beq r4,r4,+2 from PC 0x10 → r4 = 1; after the branch, iram_addr = 0x20.
- jal at PC 0x40 with target 0x100 → iram_addr = 0x400, r31 = 0x44. A following jr r31 returns iram_addr to 0x44.
- sw 0x1234 to 0xFFFF_0004, SCAN_BITS = 2, SEG_DISPLAY_EN defined → seg_an cycles 1110/1101/1011/0111 every 4 clocks with cathodes for 4,3,2,1. With the macro undefined, seg_an stays 4'b1111.
- Assert rst mid-run after writing led → iram_addr = 0 and led = 0 immediately, with no clock edge needed.
